// File: rtl/snn_pkg.sv
// ============================================================================
// Module      : snn_pkg
// Description : Shared defaults, AER event layout and width helpers for the
//               spiking-neuron datapath (lif wrappers and AER encoder).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package snn_pkg;

    localparam int N_NEURONS_DEF  = 8;
    localparam int TS_W_DEF       = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    // Address width for an n-entry neuron array; never narrower than one bit.
    function automatic int addr_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int ADDR_W_DEF = addr_width(N_NEURONS_DEF);

    typedef struct packed {
        logic [TS_W_DEF-1:0]   ts;
        logic [ADDR_W_DEF-1:0] addr;
    } aer_event_t;

endpackage

`default_nettype wire

// File: rtl/aer_fifo.sv
// ============================================================================
// Module      : aer_fifo
// Description : Synchronous show-ahead FIFO with registered storage; a push
//               into a full FIFO is refused even when a pop shares the edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aer_fifo #(
    parameter int DATA_W = 11,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      push_i,
    input  logic [DATA_W-1:0]         push_data_i,
    input  logic                      pop_i,
    output logic [DATA_W-1:0]         head_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q;
    logic [c_PTR_W-1:0] rd_ptr_q;
    logic [c_CNT_W-1:0] count_q;

    logic w_do_push;
    logic w_do_pop;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == c_CNT_W'(DEPTH));
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;
    assign head_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Storage is cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (w_do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + c_CNT_W'(1);
                2'b01:   count_q <= count_q - c_CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/spike_aer_encoder.sv
// ============================================================================
// Module      : spike_aer_encoder
// Description : Samples the lif spike vector and serialises each frame into
//               {timestamp, neuron index} AER events through a small FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spike_aer_encoder
    import snn_pkg::*;
#(
    parameter int N_NEURONS  = N_NEURONS_DEF,
    parameter int ADDR_W     = addr_width(N_NEURONS),
    parameter int TS_W       = TS_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic [N_NEURONS-1:0] spk_in,
    output logic                 aer_valid,
    input  logic                 aer_ready,
    output logic [ADDR_W-1:0]    aer_addr,
    output logic [TS_W-1:0]      aer_ts,
    output logic                 busy,
    output logic [7:0]           drop_count
);

    localparam int c_EV_W  = TS_W + ADDR_W;
    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [TS_W-1:0]      ts_cnt_q;
    logic [TS_W-1:0]      ts_cnt_d;
    logic [TS_W-1:0]      frame_ts_q;
    logic [TS_W-1:0]      frame_ts_d;
    logic [N_NEURONS-1:0] scan_q;
    logic [N_NEURONS-1:0] scan_d;
    logic [7:0]           drop_cnt_q;
    logic [7:0]           drop_cnt_d;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_spk_any;
    logic                 w_scan_single;
    logic                 w_load_ok;
    logic [ADDR_W-1:0]    w_lsb_idx;
    logic [N_NEURONS-1:0] w_lsb_mask;
    logic [c_EV_W-1:0]    w_head;
    logic [c_CNT_W-1:0]   w_fifo_count_unused;

    // Lowest set bit: returns {one-hot clear mask, index}.
    function automatic logic [N_NEURONS+ADDR_W-1:0] lsb_encode(
        input logic [N_NEURONS-1:0] v
    );
        logic [ADDR_W-1:0]    idx;
        logic [N_NEURONS-1:0] mask;
        idx  = '0;
        mask = v & (~v + N_NEURONS'(1));
        for (int i = N_NEURONS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = ADDR_W'(i);
            end
        end
        return {mask, idx};
    endfunction

    assign {w_lsb_mask, w_lsb_idx} = lsb_encode(scan_q);

    assign w_spk_any     = |spk_in;
    assign w_push        = (scan_q != '0) && !w_full;
    assign w_pop         = !w_empty && aer_ready;
    assign w_scan_single = ((scan_q & (scan_q - N_NEURONS'(1))) == '0);
    // A new frame may enter only if the scan register drains on this edge.
    assign w_load_ok     = (scan_q == '0) || (w_scan_single && w_push);

    always_comb begin
        ts_cnt_d   = ts_cnt_q;
        frame_ts_d = frame_ts_q;
        scan_d     = scan_q;
        drop_cnt_d = drop_cnt_q;
        if (w_push) begin
            scan_d = scan_q & ~w_lsb_mask;
        end
        if (en) begin
            ts_cnt_d = ts_cnt_q + TS_W'(1);
            if (w_spk_any) begin
                if (w_load_ok) begin
                    scan_d     = spk_in;
                    frame_ts_d = ts_cnt_q;
                end else if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt_q   <= '0;
            frame_ts_q <= '0;
            scan_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            ts_cnt_q   <= ts_cnt_d;
            frame_ts_q <= frame_ts_d;
            scan_q     <= scan_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    aer_fifo #(
        .DATA_W (c_EV_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (w_push),
        .push_data_i ({frame_ts_q, w_lsb_idx}),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .empty_o     (w_empty),
        .full_o      (w_full),
        .count_o     (w_fifo_count_unused)
    );

    assign aer_valid  = !w_empty;
    assign aer_addr   = w_head[ADDR_W-1:0];
    assign aer_ts     = w_head[c_EV_W-1:ADDR_W];
    assign busy       = (scan_q != '0);
    assign drop_count = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_spike_aer_encoder.sv
// ============================================================================
// Module      : tb_spike_aer_encoder
// Description : Directed self-checking bench for spike_aer_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spike_aer_encoder;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic       en        = 1'b0;
    logic       aer_ready = 1'b0;
    logic [7:0] spk_in    = 8'h00;
    logic       aer_valid;
    logic [2:0] aer_addr;
    logic [7:0] aer_ts;
    logic       busy;
    logic [7:0] drop_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    spike_aer_encoder #(
        .N_NEURONS  (8),
        .ADDR_W     (3),
        .TS_W       (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .spk_in     (spk_in),
        .aer_valid  (aer_valid),
        .aer_ready  (aer_ready),
        .aer_addr   (aer_addr),
        .aer_ts     (aer_ts),
        .busy       (busy),
        .drop_count (drop_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en        = 1'b0;
        spk_in    = 8'h00;
        aer_ready = 1'b0;
        reset_n   = 1'b0;
        tick();
        tick();
        reset_n   = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++;
        if ({aer_valid, aer_addr, aer_ts} !== 12'h000)
            $display("FAIL reset_port: got v=%b a=%0d ts=%0d want 0/0/0", aer_valid, aer_addr, aer_ts);
        else n_pass++;
        n_checks++;
        if ({busy, drop_count} !== 9'h000)
            $display("FAIL reset_status: got busy=%b drop=%0d want 0/0", busy, drop_count);
        else n_pass++;
        reset_n = 1'b1;
        tick();
        n_checks++;
        if ({aer_valid, busy, drop_count} !== 10'h000)
            $display("FAIL reset_release: got v=%b busy=%b drop=%0d want 0/0/0", aer_valid, busy, drop_count);
        else n_pass++;
    endtask

    task automatic test_single_spike();
        en        = 1'b1;
        aer_ready = 1'b1;
        spk_in    = 8'h00;
        repeat (5) tick();
        spk_in = 8'b0000_0100;
        tick();
        spk_in = 8'h00;
        n_checks++;
        if ({busy, aer_valid} !== 2'b10)
            $display("FAIL single_e0: got busy=%b v=%b want 1/0", busy, aer_valid);
        else n_pass++;
        tick();
        n_checks++;
        if ({aer_valid, aer_addr, aer_ts, busy} !== {1'b1, 3'd2, 8'd5, 1'b0})
            $display("FAIL single_event: got v=%b a=%0d ts=%0d busy=%b want 1/2/5/0", aer_valid, aer_addr, aer_ts, busy);
        else n_pass++;
        tick();
        n_checks++;
        if (aer_valid !== 1'b0)
            $display("FAIL single_valid_width: got v=%b want 0", aer_valid);
        else n_pass++;
    endtask

    task automatic test_multi_bit();
        logic [2:0] exp_a [3];
        exp_a = '{3'd1, 3'd4, 3'd7};
        do_reset();
        en        = 1'b1;
        aer_ready = 1'b1;
        spk_in    = 8'b1001_0010;
        tick();
        spk_in = 8'h00;
        n_checks++;
        if ({busy, aer_valid} !== 2'b10)
            $display("FAIL multi_e0: got busy=%b v=%b want 1/0", busy, aer_valid);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({aer_valid, aer_addr, aer_ts, busy} !== {1'b1, exp_a[i], 8'd0, (i < 2)})
                $display("FAIL multi_event%0d: got v=%b a=%0d ts=%0d busy=%b want 1/%0d/0/%b",
                         i, aer_valid, aer_addr, aer_ts, busy, exp_a[i], (i < 2));
            else n_pass++;
        end
        tick();
        n_checks++;
        if (aer_valid !== 1'b0)
            $display("FAIL multi_drain: got v=%b want 0", aer_valid);
        else n_pass++;
    endtask

    task automatic test_drop();
        do_reset();
        en        = 1'b1;
        aer_ready = 1'b1;
        spk_in    = 8'b1001_0010;
        tick();
        spk_in = 8'b0000_0001;
        tick();
        n_checks++;
        if ({aer_addr, drop_count} !== {3'd1, 8'd1})
            $display("FAIL drop_e1: got a=%0d drop=%0d want 1/1", aer_addr, drop_count);
        else n_pass++;
        tick();
        n_checks++;
        if ({aer_addr, drop_count} !== {3'd4, 8'd2})
            $display("FAIL drop_e2: got a=%0d drop=%0d want 4/2", aer_addr, drop_count);
        else n_pass++;
        tick();
        spk_in = 8'h00;
        n_checks++;
        if ({aer_valid, aer_addr, busy, drop_count} !== {1'b1, 3'd7, 1'b1, 8'd2})
            $display("FAIL drop_reload: got v=%b a=%0d busy=%b drop=%0d want 1/7/1/2",
                     aer_valid, aer_addr, busy, drop_count);
        else n_pass++;
        tick();
        n_checks++;
        if ({aer_valid, aer_addr, aer_ts} !== {1'b1, 3'd0, 8'd3})
            $display("FAIL drop_addr0: got v=%b a=%0d ts=%0d want 1/0/3", aer_valid, aer_addr, aer_ts);
        else n_pass++;
        tick();
        n_checks++;
        if (aer_valid !== 1'b0)
            $display("FAIL drop_drain: got v=%b want 0", aer_valid);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        en        = 1'b1;
        aer_ready = 1'b0;
        spk_in    = 8'hFF;
        tick();
        spk_in = 8'h00;
        repeat (4) tick();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({aer_valid, aer_addr, aer_ts, busy} !== {1'b1, 3'd0, 8'd0, 1'b1})
                $display("FAIL bp_hold%0d: got v=%b a=%0d ts=%0d busy=%b want 1/0/0/1",
                         i, aer_valid, aer_addr, aer_ts, busy);
            else n_pass++;
            tick();
        end
        aer_ready = 1'b1;
        for (int a = 1; a < 8; a++) begin
            tick();
            n_checks++;
            if ({aer_valid, aer_addr, aer_ts} !== {1'b1, 3'(a), 8'd0})
                $display("FAIL bp_drain%0d: got v=%b a=%0d ts=%0d want 1/%0d/0", a, aer_valid, aer_addr, aer_ts, a);
            else n_pass++;
        end
        tick();
        n_checks++;
        if ({aer_valid, busy} !== 2'b00)
            $display("FAIL bp_empty: got v=%b busy=%b want 0/0", aer_valid, busy);
        else n_pass++;
    endtask

    task automatic test_ts_wrap();
        do_reset();
        en        = 1'b1;
        aer_ready = 1'b1;
        for (int i = 0; i < 255; i++) begin
            spk_in = (i == 100) ? 8'h40 : 8'h00;
            tick();
            if (i == 101) begin
                n_checks++;
                if ({aer_valid, aer_addr, aer_ts} !== {1'b1, 3'd6, 8'd100})
                    $display("FAIL wrap_sparse: got v=%b a=%0d ts=%0d want 1/6/100", aer_valid, aer_addr, aer_ts);
                else n_pass++;
            end
        end
        spk_in = 8'b0000_1000;
        tick();
        spk_in = 8'b0000_0010;
        tick();
        spk_in = 8'h00;
        n_checks++;
        if ({aer_valid, aer_addr, aer_ts} !== {1'b1, 3'd3, 8'd255})
            $display("FAIL wrap_ts255: got v=%b a=%0d ts=%0d want 1/3/255", aer_valid, aer_addr, aer_ts);
        else n_pass++;
        tick();
        n_checks++;
        if ({aer_valid, aer_addr, aer_ts} !== {1'b1, 3'd1, 8'd0})
            $display("FAIL wrap_ts0: got v=%b a=%0d ts=%0d want 1/1/0", aer_valid, aer_addr, aer_ts);
        else n_pass++;
        tick();
        n_checks++;
        if (aer_valid !== 1'b0)
            $display("FAIL wrap_drain: got v=%b want 0", aer_valid);
        else n_pass++;
    endtask

    task automatic test_drop_saturation();
        do_reset();
        en        = 1'b1;
        aer_ready = 1'b0;
        spk_in    = 8'hFF;
        tick();
        spk_in = 8'h01;
        repeat (254) tick();
        n_checks++;
        if (drop_count !== 8'd254)
            $display("FAIL sat_254: got drop=%0d want 254", drop_count);
        else n_pass++;
        tick();
        n_checks++;
        if (drop_count !== 8'd255)
            $display("FAIL sat_255: got drop=%0d want 255", drop_count);
        else n_pass++;
        repeat (45) tick();
        spk_in = 8'h00;
        n_checks++;
        if ({drop_count, busy} !== {8'd255, 1'b1})
            $display("FAIL sat_hold: got drop=%0d busy=%b want 255/1", drop_count, busy);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        en        = 1'b1;
        aer_ready = 1'b0;
        repeat (3) tick();
        spk_in = 8'hFF;
        tick();
        spk_in = 8'h01;
        tick();
        spk_in = 8'h00;
        tick();
        tick();
        n_checks++;
        if ({aer_valid, aer_addr, aer_ts, drop_count} !== {1'b1, 3'd0, 8'd3, 8'd1})
            $display("FAIL arst_pre: got v=%b a=%0d ts=%0d drop=%0d want 1/0/3/1",
                     aer_valid, aer_addr, aer_ts, drop_count);
        else n_pass++;
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({aer_valid, aer_addr, aer_ts, busy, drop_count} !== 20'h00000)
            $display("FAIL arst_immediate: got v=%b a=%0d ts=%0d busy=%b drop=%0d want all 0",
                     aer_valid, aer_addr, aer_ts, busy, drop_count);
        else n_pass++;
        tick();
        reset_n   = 1'b1;
        aer_ready = 1'b1;
        spk_in    = 8'h01;
        tick();
        spk_in = 8'h00;
        tick();
        n_checks++;
        if ({aer_valid, aer_addr, aer_ts} !== {1'b1, 3'd0, 8'd0})
            $display("FAIL arst_first_frame: got v=%b a=%0d ts=%0d want 1/0/0", aer_valid, aer_addr, aer_ts);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_spike();
        test_multi_bit();
        test_drop();
        test_backpressure();
        test_ts_wrap();
        test_drop_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks, want completion", n_checks);
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/spike_aer_encoder.md
# spike_aer_encoder

Downstream stage of the `lif` neuron array: samples the per-neuron spike vector every enabled cycle and serialises it into address-event representation (AER) words of neuron index plus timestamp. Events pass through a small FIFO to a valid/ready output port that feeds the chip's spike output bus and monitoring logic. Spikes that arrive while a previous frame is still being serialised are dropped and counted.

## Interface
- `N_NEURONS`, default 8: width of the spike vector; must be at least 2.
- `ADDR_W`, default 3: event address width, equal to ceil(log2(`N_NEURONS`)).
- `TS_W`, default 8: timestamp width.
- `FIFO_DEPTH`, default 4: event FIFO entries; must be a power of 2.
- `clk`  in  1: single clock; all state is updated on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: sampling enable; when low, spikes are ignored and the timestamp counter holds.
- `spk_in`  in  `N_NEURONS`: spike vector, one bit per `lif` instance.
- `aer_valid`  out  1: head FIFO entry is valid.
- `aer_ready`  in  1: consumer accepts the head entry.
- `aer_addr`  out  `ADDR_W`: neuron index of the head event.
- `aer_ts`  out  `TS_W`: timestamp of the head event.
- `busy`  out  1: the scan register is non-zero.
- `drop_count`  out  8: count of dropped frames, saturating.

## Operation
- Timestamp counter `ts_cnt` (`TS_W` bits):
  - Increments on each edge with `en`=1.
  - Wraps from 2^`TS_W`-1 to 0.
- Scan register `scan` (`N_NEURONS`) and frame timestamp `frame_ts`.
- Load condition, `load_ok`: the scan register is empty after this edge. That holds when `scan`==0, or when `scan` has exactly one bit set and that bit is pushed this cycle.
- Load: on an edge with `en`=1, `load_ok`=1 and `spk_in`!=0:
  - `scan` <= `spk_in`.
  - `frame_ts` <= `ts_cnt` (the pre-increment value).
- Drop: on an edge with `en`=1, `load_ok`=0 and `spk_in`!=0:
  - `drop_count` increments by 1 (one count per frame, not per spike).
  - It saturates at 255.
  - `scan` is unchanged.
- Push: on each edge where `scan`!=0 and the FIFO is not full:
  - Write {`frame_ts`, index of the lowest set bit of `scan`} into the FIFO.
  - Clear that bit.
  - At most one push per cycle.
- A full FIFO blocks the push even when a pop happens on the same edge, so no push-on-full bypass exists.
- Pop: on an edge where `aer_valid`=1 and `aer_ready`=1, the head entry is removed.
- Output port:
  - `aer_valid`, `aer_addr` and `aer_ts` are driven from FIFO registers (show-ahead).
  - While `aer_valid`=1 and `aer_ready`=0, these outputs are held stable.
- Reset mid-operation clears the scan register, the FIFO, `ts_cnt` and `drop_count` immediately. In-flight events are discarded.

## Timing
- Reset values:
  - `aer_valid`=0, `aer_addr`=0, `aer_ts`=0.
  - `busy`=0, `drop_count`=0.
  - Internal `ts_cnt`, `scan`, `frame_ts`, FIFO pointers and count are all 0.
- Latency:
  - `spk_in` is sampled at edge E0.
  - The first event is pushed at E1, and `aer_valid`=1 after E1.
  - A frame with k set bits, with the FIFO never full, completes its pushes at edge E(k).
- Back-to-back frames:
  - A single-bit frame permits a new load on every edge.
  - A k-bit frame blocks loads for k-1 edges.
- Push and pop on the same edge with the FIFO non-full and non-empty: the count is unchanged and the ordering is preserved.
- Throughput: 1 event per clock with `aer_ready` held high.

## Structure
- Package `snn_pkg`:
  - `aer_event_t` struct {ts, addr}.
  - `ADDR_W` derivation function (clog2).
  - Default-parameter constants shared with `lif` wrappers.
- Sub-module `aer_fifo`:
  - Parameterised synchronous FIFO.
  - Ports: `clk`, `reset_n`, push/data, pop, `empty`/`full`/`count`.
  - Show-ahead read and registered storage.
- Priority encoder (lowest set bit to index, plus one-hot clear mask) stays a function inside `spike_aer_encoder`.

## Test plan
- Reset, then `en`=1, `spk_in`=8'b0000_0100 for one cycle at `ts_cnt`=5, `aer_ready`=1 → one event addr=2, ts=5, with `aer_valid` high exactly 1 cycle, 2 edges after sampling.
- `spk_in`=8'b1001_0010 for one cycle at `ts_cnt`=0 → events in order addr 1, 4, 7, all with ts=0, on consecutive cycles; `busy` high for 3 cycles.
- Same 3-bit frame, then `spk_in`=8'b0000_0001 on each of the next 2 cycles → `drop_count`=2 and no addr-0 events. A third cycle of `spk_in`=1, arriving on the edge where the last bit is pushed, loads and yields addr=0.
- `aer_ready`=0 with `spk_in`=8'hFF at `FIFO_DEPTH`=4 → 4 events buffered, `busy` stays 1 and outputs are held stable. Raising `aer_ready` drains addr 0..7 in order with no loss.
- Hold `en`=1 for 260 cycles with sparse single spikes, and force `drop_count` saturation with 300 blocked frames → `ts_cnt` wraps 255→0 in the event ts, and `drop_count` stops at 255.
- Assert `reset_n`=0 asynchronously (between clock edges) mid-frame with the FIFO holding 3 entries → `aer_valid`=0 immediately and `drop_count`=0. After release, the first new frame gets ts=0.
